// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS pipeline with a multiply/divide scoreboard.
// Provides E-stage and D-stage forwarding selects, load-use / branch / MDU
// stalls, jump flush, and a saturating count of stalled cycles.
module hazard_unit_mc #(
  parameter int REG_W   = 5,
  parameter int SEL_W   = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_d,
  input  logic             jmp_d,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] write_reg_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic [REG_W-1:0] write_reg_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem2reg_e,
  input  logic             mem2reg_m,
  input  logic             mdu_start_e,
  input  logic             mdu_op_d,
  output logic [SEL_W-1:0] forward_a_e,
  output logic [SEL_W-1:0] forward_b_e,
  output logic             forward_a_d,
  output logic             forward_b_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             mdu_busy,
  output logic             mdu_wb,
  output logic [REG_W-1:0] mdu_dst,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MC_W = $clog2(MDU_LAT + 1);

  localparam logic [SEL_W-1:0] FWD_RF = SEL_W'(0);
  localparam logic [SEL_W-1:0] FWD_W  = SEL_W'(1);
  localparam logic [SEL_W-1:0] FWD_M  = SEL_W'(2);

  logic [MC_W-1:0]  mdu_cnt_q,   mdu_cnt_d;
  logic [REG_W-1:0] mdu_dst_q,   mdu_dst_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lw_stall, br_stall, mdu_stall;
  logic e_hits_d, m_hits_d, mdu_hits_d;

  // E-stage source select: M result wins over W, register 0 never forwards.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                               input logic [REG_W-1:0] wr_m,
                                               input logic             rw_m,
                                               input logic [REG_W-1:0] wr_w,
                                               input logic             rw_w);
    if (src != '0 && src == wr_m && rw_m)      return FWD_M;
    else if (src != '0 && src == wr_w && rw_w) return FWD_W;
    else                                       return FWD_RF;
  endfunction

  // Forwarding selects for the E-stage ALU and the D-stage branch comparator.
  always_comb begin
    forward_a_e = fwd_sel(rs_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
    forward_b_e = fwd_sel(rt_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
    forward_a_d = (rs_d != '0) && (rs_d == write_reg_m) && reg_write_m;
    forward_b_d = (rt_d != '0) && (rt_d == write_reg_m) && reg_write_m;
  end

  // Stall / flush decode from the current pipeline and scoreboard state.
  always_comb begin
    e_hits_d   = (write_reg_e != '0) && (write_reg_e == rs_d || write_reg_e == rt_d);
    m_hits_d   = (write_reg_m != '0) && (write_reg_m == rs_d || write_reg_m == rt_d);
    mdu_hits_d = (mdu_dst_q   != '0) && (mdu_dst_q   == rs_d || mdu_dst_q   == rt_d);

    lw_stall  = mem2reg_e && e_hits_d;
    br_stall  = branch_d && ((reg_write_e && e_hits_d) || (mem2reg_m && m_hits_d));
    // The register file is write-first, so a dependent instruction is held
    // only while the result is still pending; it proceeds the cycle after mdu_wb.
    mdu_stall = mdu_busy && (mdu_op_d || mdu_hits_d);

    stall_d = lw_stall || br_stall || mdu_stall;
    stall_f = stall_d;
    flush_e = stall_d || jmp_d;
  end

  assign mdu_busy  = (mdu_cnt_q != '0);
  assign mdu_wb    = (mdu_cnt_q == MC_W'(1));
  assign mdu_dst   = mdu_dst_q;
  assign stall_cnt = stall_cnt_q;

  // Next-state for the MDU scoreboard and the saturating stall counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mdu_cnt_d   = mdu_cnt_q;
    mdu_dst_d   = mdu_dst_q;
    stall_cnt_d = stall_cnt_q;

    // A start while busy (including the mdu_wb cycle) is ignored; a flush
    // in E does not cancel an op that has already been accepted.
    if (!mdu_busy) begin
      if (mdu_start_e) begin
        mdu_cnt_d = MC_W'(MDU_LAT);
        mdu_dst_d = write_reg_e;
      end
    end else begin
      mdu_cnt_d = mdu_cnt_q - MC_W'(1);
    end

    if (stall_d && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers; reset clears the scoreboard mid-op so no mdu_wb follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt_q   <= '0;
      mdu_dst_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      mdu_cnt_q   <= mdu_cnt_d;
      mdu_dst_q   <= mdu_dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: a table of combinational vectors plus
// hand-written multi-cycle sequences for the MDU scoreboard, stall counter
// and reset.
module tb_hazard_unit_mc;

  localparam int REG_W   = 5;
  localparam int SEL_W   = 2;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;   // small so saturation is reachable quickly

  logic             clk = 1'b0;
  logic             rst_n;
  logic             branch_d, jmp_d;
  logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_W-1:0] write_reg_e, write_reg_m, write_reg_w;
  logic             reg_write_e, reg_write_m, reg_write_w;
  logic             mem2reg_e, mem2reg_m, mdu_start_e, mdu_op_d;
  logic [SEL_W-1:0] forward_a_e, forward_b_e;
  logic             forward_a_d, forward_b_d;
  logic             stall_f, stall_d, flush_e;
  logic             mdu_busy, mdu_wb;
  logic [REG_W-1:0] mdu_dst;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_W(REG_W), .SEL_W(SEL_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_d(branch_d), .jmp_d(jmp_d),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem2reg_e(mem2reg_e), .mem2reg_m(mem2reg_m),
    .mdu_start_e(mdu_start_e), .mdu_op_d(mdu_op_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_dst(mdu_dst), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string      name;
    logic       br, jmp;
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       rwe, rwm, rww, m2re, m2rm, mop;
    logic [1:0] fa_e, fb_e;
    logic       fa_d, fb_d, stall, flush;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    branch_d = 0; jmp_d = 0;
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem2reg_e = 0; mem2reg_m = 0; mdu_start_e = 0; mdu_op_d = 0;
  endtask

  // Move to the middle of the next cycle; inputs change here, away from posedge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();

    //                 name       br jmp rsd rtd rse rte wre wrm wrw rwe rwm rww m2re m2rm mop  fa_e  fb_e  fad fbd st fl
    vecs.push_back('{"fwd_m",     0, 0,  0,  0,  3,  3,  0,  3,  3,  0,  1,  1,  0,   0,   0,  2'b10,2'b10,0,  0,  0, 0});
    vecs.push_back('{"fwd_w",     0, 0,  0,  0,  3,  3,  0,  3,  3,  0,  0,  1,  0,   0,   0,  2'b01,2'b01,0,  0,  0, 0});
    vecs.push_back('{"fwd_rf",    0, 0,  0,  0,  3,  3,  0,  3,  3,  0,  0,  0,  0,   0,   0,  2'b00,2'b00,0,  0,  0, 0});
    vecs.push_back('{"fwd_r0",    0, 0,  0,  0,  0,  3,  0,  0,  0,  0,  1,  1,  0,   0,   0,  2'b00,2'b00,0,  0,  0, 0});
    vecs.push_back('{"fwd_mix",   0, 0,  0,  0,  3,  4,  0,  4,  3,  0,  1,  1,  0,   0,   0,  2'b01,2'b10,0,  0,  0, 0});
    vecs.push_back('{"lw_use",    0, 0,  0,  8,  0,  0,  8,  0,  0,  1,  0,  0,  1,   0,   0,  2'b00,2'b00,0,  0,  1, 1});
    vecs.push_back('{"lw_r0",     0, 0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  1,   0,   0,  2'b00,2'b00,0,  0,  0, 0});
    vecs.push_back('{"br_e",      1, 0,  5,  0,  0,  0,  5,  0,  0,  1,  0,  0,  0,   0,   0,  2'b00,2'b00,0,  0,  1, 1});
    vecs.push_back('{"br_fwd_m",  1, 0,  5,  0,  0,  0,  0,  5,  0,  0,  1,  0,  0,   0,   0,  2'b00,2'b00,1,  0,  0, 0});
    vecs.push_back('{"br_ld_m",   1, 0,  0,  6,  0,  0,  0,  6,  0,  0,  1,  0,  0,   1,   0,  2'b00,2'b00,0,  1,  1, 1});
    vecs.push_back('{"br_e_r0",   1, 0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  0,   0,   0,  2'b00,2'b00,0,  0,  0, 0});
    vecs.push_back('{"fwd_d_r0",  0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,   0,   0,  2'b00,2'b00,0,  0,  0, 0});
    vecs.push_back('{"jmp_only",  0, 1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,   0,  2'b00,2'b00,0,  0,  0, 1});
    vecs.push_back('{"mop_idle",  0, 0,  9,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,   1,  2'b00,2'b00,0,  0,  0, 0});

    // Reset state
    #2;
    check("rst_busy", 32'(mdu_busy), 0);
    check("rst_wb",   32'(mdu_wb), 0);
    check("rst_dst",  32'(mdu_dst), 0);
    check("rst_cnt",  32'(stall_cnt), 0);
    do_reset();

    // Combinational table (scoreboard idle throughout)
    foreach (vecs[i]) begin
      next_cycle();
      branch_d = vecs[i].br;  jmp_d = vecs[i].jmp;
      rs_d = vecs[i].rsd; rt_d = vecs[i].rtd; rs_e = vecs[i].rse; rt_e = vecs[i].rte;
      write_reg_e = vecs[i].wre; write_reg_m = vecs[i].wrm; write_reg_w = vecs[i].wrw;
      reg_write_e = vecs[i].rwe; reg_write_m = vecs[i].rwm; reg_write_w = vecs[i].rww;
      mem2reg_e = vecs[i].m2re; mem2reg_m = vecs[i].m2rm; mdu_op_d = vecs[i].mop;
      mdu_start_e = 0;
      #1;
      check({vecs[i].name, ".fa_e"},  32'(forward_a_e), 32'(vecs[i].fa_e));
      check({vecs[i].name, ".fb_e"},  32'(forward_b_e), 32'(vecs[i].fb_e));
      check({vecs[i].name, ".fa_d"},  32'(forward_a_d), 32'(vecs[i].fa_d));
      check({vecs[i].name, ".fb_d"},  32'(forward_b_d), 32'(vecs[i].fb_d));
      check({vecs[i].name, ".stl_d"}, 32'(stall_d), 32'(vecs[i].stall));
      check({vecs[i].name, ".stl_f"}, 32'(stall_f), 32'(vecs[i].stall));
      check({vecs[i].name, ".flush"}, 32'(flush_e), 32'(vecs[i].flush));
    end

    // Load-use for one cycle counts once; write_reg_e=0 never counts
    do_reset();
    mem2reg_e = 1; write_reg_e = 8; rt_d = 8;
    #1 check("lu_stall", 32'(stall_d), 1);
    next_cycle();
    idle_inputs();
    #1 check("lu_cnt1", 32'(stall_cnt), 1);
    check("lu_release", 32'(stall_d), 0);
    mem2reg_e = 1; write_reg_e = 0; rt_d = 0;
    next_cycle();
    idle_inputs();
    #1 check("lu_r0_cnt", 32'(stall_cnt), 1);

    // MDU data dependency: start at cycle 0, rs_d=9 from cycle 1
    do_reset();
    mdu_start_e = 1; write_reg_e = 9;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      mdu_start_e = 0; write_reg_e = 0; rs_d = 9;
      #1;
      check($sformatf("dep_busy_c%0d", c),  32'(mdu_busy), (c <= 4) ? 1 : 0);
      check($sformatf("dep_wb_c%0d", c),    32'(mdu_wb),   (c == 4) ? 1 : 0);
      check($sformatf("dep_stall_c%0d", c), 32'(stall_d),  (c <= 4) ? 1 : 0);
      check($sformatf("dep_dst_c%0d", c),   32'(mdu_dst),  9);
    end
    check("dep_cnt", 32'(stall_cnt), 4);

    // MDU structural: mdu_op_d while busy; stray starts at cycle 2 and at the wb cycle
    do_reset();
    mdu_start_e = 1; write_reg_e = 9;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      rs_d = 0; mdu_op_d = 1;
      mdu_start_e = (c == 2 || c == 4);
      write_reg_e = (c == 2) ? 5'd7 : (c == 4) ? 5'd6 : 5'd0;
      #1;
      check($sformatf("str_busy_c%0d", c),  32'(mdu_busy), (c <= 4) ? 1 : 0);
      check($sformatf("str_wb_c%0d", c),    32'(mdu_wb),   (c == 4) ? 1 : 0);
      check($sformatf("str_stall_c%0d", c), 32'(stall_d),  (c <= 4) ? 1 : 0);
      check($sformatf("str_dst_c%0d", c),   32'(mdu_dst),  9);
    end
    idle_inputs();

    // Start with destination 0: structural occupancy, no data stall
    do_reset();
    mdu_start_e = 1; write_reg_e = 0;
    next_cycle();
    mdu_start_e = 0;
    #1;
    check("r0_busy",  32'(mdu_busy), 1);
    check("r0_stall", 32'(stall_d), 0);
    mdu_op_d = 1;
    #1 check("r0_op_stall", 32'(stall_d), 1);
    idle_inputs();

    // Reset mid-operation: clears at once, no late mdu_wb
    do_reset();
    mdu_start_e = 1; write_reg_e = 9;
    next_cycle();
    mdu_start_e = 0; write_reg_e = 0; rs_d = 9;
    next_cycle();
    #1 check("mid_busy_pre", 32'(mdu_busy), 1);
    check("mid_cnt_pre", 32'(stall_cnt), 1);
    rst_n = 0;
    #1;
    check("mid_busy", 32'(mdu_busy), 0);
    check("mid_wb",   32'(mdu_wb), 0);
    check("mid_dst",  32'(mdu_dst), 0);
    check("mid_cnt",  32'(stall_cnt), 0);
    next_cycle();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      #1 check($sformatf("mid_nowb_%0d", c), 32'(mdu_wb), 0);
    end
    idle_inputs();

    // Stall counter saturates at 2^CNT_W-1
    do_reset();
    mem2reg_e = 1; write_reg_e = 8; rt_d = 8;
    repeat (20) next_cycle();
    #1 check("sat_cnt", 32'(stall_cnt), 15);
    next_cycle();
    #1 check("sat_hold", 32'(stall_cnt), 15);
    idle_inputs();

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline.
- Adds a sequential scoreboard for a variable-latency multiply/divide unit (MDU) that writes a GPR after MDU_LAT cycles.
- Adds MDU structural-hazard stalling and a saturating stall-cycle performance counter.
- Keeps the existing hazard behaviour: E-stage forwarding (M/W), D-stage branch forwarding, load-use stall, branch-compare stall and jump flush. W-stage forwarding is qualified by reg_write_w.

Parameters:
- REG_W, 5, register-index width
- SEL_W, 2, E-stage forward-select width
- MDU_LAT, 4, MDU cycles from issue in E to register-file write (>=2)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- branch_d  in  1  branch in D
- jmp_d  in  1  jump in D
- rs_d, rt_d  in  REG_W  D-stage sources
- rs_e, rt_e  in  REG_W  E-stage sources
- write_reg_e, write_reg_m, write_reg_w  in  REG_W  destinations in E/M/W
- reg_write_e, reg_write_m, reg_write_w  in  1  register-file write enables in E/M/W
- mem2reg_e, mem2reg_m  in  1  load in E/M
- mdu_start_e  in  1  MDU op issuing from E; destination is write_reg_e
- mdu_op_d  in  1  instruction in D is an MDU op
- forward_a_e, forward_b_e  out  SEL_W  00 regfile, 01 W, 10 M
- forward_a_d, forward_b_d  out  1  forward M result to branch comparator
- stall_f, stall_d, flush_e  out  1  pipeline control
- mdu_busy  out  1  scoreboard occupied
- mdu_wb  out  1  one-cycle strobe: MDU writes mdu_dst this cycle
- mdu_dst  out  REG_W  pending MDU destination
- stall_cnt  out  CNT_W  cycles with stall_d=1, saturating

Behaviour:
- Reset (async, rst_n=0): mdu_cnt=0, mdu_dst=0, stall_cnt=0. Therefore mdu_busy=0 and mdu_wb=0. Combinational outputs follow the inputs with mdu_busy=0.
- E forwarding, A side (B identical with rt_e):
  - 10 if rs_e!=0 & rs_e==write_reg_m & reg_write_m;
  - else 01 if rs_e!=0 & rs_e==write_reg_w & reg_write_w;
  - else 00.
  - M has priority over W.
- D forwarding: forward_a_d = rs_d!=0 & rs_d==write_reg_m & reg_write_m; forward_b_d is the same with rt_d.
- lw_stall = mem2reg_e & write_reg_e!=0 & (rs_d==write_reg_e | rt_d==write_reg_e).
- br_stall = branch_d & [(reg_write_e & write_reg_e!=0 & write_reg_e∈{rs_d,rt_d}) | (mem2reg_m & write_reg_m!=0 & write_reg_m∈{rs_d,rt_d})].
- mdu_stall = mdu_busy & [mdu_op_d | (mdu_dst!=0 & mdu_dst∈{rs_d,rt_d})].
- stall_f = stall_d = lw_stall | br_stall | mdu_stall.
- flush_e = stall_d | jmp_d.
- Scoreboard (mdu_cnt, $clog2(MDU_LAT+1) bits, registered):
  - IDLE (mdu_cnt==0): if mdu_start_e, then mdu_cnt<=MDU_LAT and mdu_dst<=write_reg_e.
  - BUSY (mdu_cnt>0): mdu_cnt decrements by 1 each cycle.
  - mdu_busy = mdu_cnt!=0.
  - mdu_wb = mdu_cnt==1.
  - mdu_dst holds its value until the next accepted start.
  - Dependent D instruction is released the cycle after mdu_wb. The register file is write-first, so no MDU forwarding path exists.
- mdu_start_e while BUSY cannot occur in legal flow (mdu_op_d stalls). If it occurs: ignored, counter undisturbed.
- mdu_start_e in the same cycle as mdu_wb: ignored, because the unit is still busy that cycle.
- mdu_start_e with write_reg_e==0: accepted and occupies the unit (structural stall), but causes no data stall.
- flush_e does not cancel an accepted MDU op; the flush bubbles the instruction entering E next cycle.
- stall_cnt: increments on every clock with stall_d=1 and saturates at 2^CNT_W-1.
- Reset mid-operation: scoreboard and counter clear immediately; mdu_wb is not issued.

Test Plan:
- Forwarding: rs_e=rt_e=3, write_reg_m=write_reg_w=3, reg_write_m=reg_write_w=1 -> forward_a_e=forward_b_e=10. Then reg_write_m=0 -> 01. Then reg_write_w=0 -> 00. rs_e=0 -> 00 always.
- Load-use: mem2reg_e=1, write_reg_e=8, rt_d=8 -> stall_f=stall_d=flush_e=1 for 1 cycle; stall_cnt 0->1. Same with write_reg_e=0 -> no stall.
- Branch: branch_d=1, rs_d=5, reg_write_e=1, write_reg_e=5 -> stall. Next cycle write_reg_m=5, reg_write_m=1, mem2reg_m=0 -> no stall, forward_a_d=1.
- MDU dependency, MDU_LAT=4: mdu_start_e with write_reg_e=9 at cycle 0; rs_d=9 from cycle 1 -> mdu_busy cycles 1-4, mdu_wb only at cycle 4, stall_d cycles 1-4, released cycle 5, stall_cnt=4.
- MDU structural: second mdu_op_d while busy -> stalls until the cycle after mdu_wb. A mdu_start_e forced during busy does not reload mdu_cnt or mdu_dst.
- Reset: rst_n low at cycle 2 of an MDU op -> mdu_busy, mdu_wb, stall_cnt, mdu_dst = 0 asynchronously; no mdu_wb after release. Also check jmp_d alone -> flush_e=1, stall_d=0.
